// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpNop = 2'd0,
        OpAdd = 2'd1,
        OpSub = 2'd2
    } booth_op_e;

    // Width needed to hold values 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/adder_rca.sv
// Plain ripple-carry adder: sum = x + y + carry_in.
module adder_rca #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic             carry_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    logic [Width:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = carry_i;
        for (int unsigned i = 0; i < Width; i++) begin
            sum_o[i]   = x_i[i] ^ y_i[i] ^ carry[i];
            carry[i+1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
        end
    end

    assign carry_o = carry[Width];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/sub-and-shift per clock, W steps per product.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned CntW = clog2(W);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [W:0]      acc_q;
    logic [W:0]      m_q;
    logic [W-1:0]    q_q;
    logic            q_m1_q;
    logic            done_q;
    logic [2*W-1:0]  product_q;

    booth_op_e       op;
    logic [W:0]      add_y;
    logic            add_cin;
    logic [W:0]      add_sum;
    logic            unused_carry;
    logic [W:0]      step_sum;
    logic [W:0]      acc_d;
    logic [W-1:0]    q_d;
    logic            q_m1_d;

    always_comb begin
        case ({q_q[0], q_m1_q})
            2'b01:   op = OpAdd;
            2'b10:   op = OpSub;
            default: op = OpNop;
        endcase
    end

    // Subtraction reuses the adder as A + ~M + 1.
    assign add_y   = (op == OpSub) ? ~m_q : m_q;
    assign add_cin = (op == OpSub);

    adder_rca #(
        .Width (W + 1)
    ) u_adder (
        .x_i     (acc_q),
        .y_i     (add_y),
        .carry_i (add_cin),
        .sum_o   (add_sum),
        .carry_o (unused_carry)
    );

    always_comb begin
        step_sum = (op == OpNop) ? acc_q : add_sum;
        acc_d    = {step_sum[W], step_sum[W:1]};
        q_d      = {step_sum[0], q_q[W-1:1]};
        q_m1_d   = q_q[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= '0;
                        q_q     <= b;
                        q_m1_q  <= 1'b0;
                        m_q     <= {a[W-1], a};
                        cnt_q   <= '0;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    acc_q  <= acc_d;
                    q_q    <= q_d;
                    q_m1_q <= q_m1_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(W - 1)) begin
                        product_q <= {acc_d[W-1:0], q_d};
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready   = (state_q == StIdle);
    assign done    = done_q;
    assign product = product_q;

endmodule
